dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//   MEM-stage data-memory access controller; drives the MEM->WB pipeline register inputs (load data, addr low bits).
//   Turns the EX/MEM load/store request into a req/ack bus transaction with byte-lane strobes.
//   Aligns and extends returned load data, and stalls the pipeline until the transaction completes.
// PARAMETERS
//   TIMEOUT_CYCLES  256  cycles in BUSY without bus_ack before abort; 0 = never time out
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   mem_rd     in   1   load request from EX/MEM
//   mem_wr     in   1   store request from EX/MEM; wins if mem_rd also high
//   mem_size   in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   mem_sign   in   1   1 = sign-extend load, 0 = zero-extend
//   addr       in   32  byte address
//   wdata      in   32  store data, right-justified
//   stall      out  1   freeze PC/IF/ID/EX/MEM regs; combinational
//   rd_data    out  32  aligned/extended load data to MEM->WB
//   addr_lo    out  2   addr[1:0] of completed access to MEM->WB
//   bus_req    out  1   bus request, held until ack
//   bus_we     out  1   1 = write
//   bus_addr   out  32  word-aligned address {addr[31:2],2'b00}
//   bus_be     out  4   byte enables, bit0 = bits 7:0 (little-endian)
//   bus_wdata  out  32  lane-replicated store data
//   bus_ack    in   1   one-cycle completion from memory
//   bus_rdata  in   32  read word, valid with bus_ack
//   bus_err    out  1   one-cycle pulse on timeout abort (or misalign when enabled)
// BEHAVIOUR
//   Reset: state IDLE, all outputs 0; async reset mid-transaction drops bus_req immediately.
//   FSM IDLE -> BUSY when (mem_rd|mem_wr) at clock edge; bus_* registered, bus_req high from next cycle.
//   BUSY: bus_req/we/addr/be/wdata held stable; bus_ack -> DONE, capture aligned rd_data and addr_lo.
//   DONE: exactly one cycle, stall low, pipeline advances; unconditional -> IDLE (no re-issue).
//   stall = (IDLE & (mem_rd|mem_wr)) | BUSY; low in DONE and in IDLE with no access.
//   Latency: load with ack in first BUSY cycle = 3 cycles (IDLE, BUSY, DONE); each extra wait cycle +1.
//   Store lanes: byte be=0001<<addr[1:0], wdata={4{b}}; half be=0011<<{addr[1],1'b0},
//     wdata={2{h}}; word be=1111.
//   Load: byte lane addr[1:0], half lane addr[1]; extend per mem_sign to 32 bits; stores leave rd_data=0.
//   Timeout: counter cleared on entering BUSY; at TIMEOUT_CYCLES without ack -> drop req, bus_err pulse,
//     rd_data=0, go DONE.
//   bus_ack outside BUSY is ignored; ack and timeout in same cycle -> ack wins, no bus_err.
// CONFIGURATION
//   DMEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no bus cycle;
//     IDLE -> DONE directly, bus_err pulses, rd_data=0.
//   Undefined: low address bits of half/word ignored, access goes to bus word-aligned.
// STRUCTURE
//   Package dmem_pkg: SIZE_BYTE/HALF/WORD constants, state enum IDLE/BUSY/DONE, be-decode function.
//   Sub-module dmem_load_align: combinational lane select + sign/zero extend (bus_rdata, addr_lo, size, sign).
// TESTING
//   LB addr=0x103, mem_sign=1, rdata=0x80xxxxxx, ack in first BUSY -> rd_data=0xFFFFFF80, stall 2 cycles.
//   SH addr=0x102, wdata=0x0000BEEF -> bus_be=1100, bus_wdata=0xBEEFBEEF, bus_addr=0x100.
//   LW with ack after 5 wait cycles -> bus_req held 6 cycles, signals stable, DONE exactly one cycle.
//   No ack, TIMEOUT_CYCLES=8 -> bus_err pulse after 8 BUSY cycles, rd_data=0, stall released.
//   Reset asserted during BUSY -> bus_req=0 same cycle, state IDLE, all outputs 0.
//   DMEM_MISALIGN_TRAP_EN, LW addr=0x101 -> no bus_req, bus_err pulse, one-cycle stall.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the MEM-stage data-memory access controller.
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // The reserved size code 2'b11 falls into the default arm and behaves as a word.
   function automatic logic [3:0] be_decode(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         SIZE_BYTE: be = 4'b0001 << lo;
         SIZE_HALF: be = 4'b0011 << {lo[1], 1'b0};
         default:   be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] lanes;
      case (size)
         SIZE_BYTE: lanes = {4{wdata[7:0]}};
         SIZE_HALF: lanes = {2{wdata[15:0]}};
         default:   lanes = wdata;
      endcase
      return lanes;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic mis;
      case (size)
         SIZE_BYTE: mis = 1'b0;
         SIZE_HALF: mis = lo[0];
         default:   mis = (lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-data lane selection and sign/zero extension of the returned bus word.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] bus_rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] load_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed lane, then widen it to 32 bits.
   always_comb begin
      byte_s = bus_rdata[{addr_lo, 3'b000} +: 8];
      half_s = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (size)
         SIZE_BYTE: load_data = {{24{sign & byte_s[7]}}, byte_s};
         SIZE_HALF: load_data = {{16{sign & half_s[15]}}, half_s};
         default:   load_data = bus_rdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store controller: req/ack bus transaction, byte strobes, load alignment, stall.
// Optional misalignment trap enabled with `define DMEM_MISALIGN_TRAP_EN.
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [1:0]  mem_size,
   input  logic        mem_sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rd_data,
   output logic [1:0]  addr_lo,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_err
);

   localparam int CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam int TO_LAST = (TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1;

   state_e            state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [31:0]       bus_addr_q, bus_addr_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic              bus_err_q, bus_err_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [1:0]        lo_q, lo_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              access_s;
   logic              trap_s;
   logic              timeout_s;
   logic [31:0]       load_data_s;

   assign access_s  = mem_rd | mem_wr;
   assign timeout_s = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

`ifdef DMEM_MISALIGN_TRAP_EN
   assign trap_s = misaligned(mem_size, addr[1:0]);
`else
   assign trap_s = 1'b0;
`endif

   dmem_load_align u_load_align (
      .bus_rdata (bus_rdata),
      .addr_lo   (lo_q),
      .size      (size_q),
      .sign      (sign_q),
      .load_data (load_data_s)
   );

   // Next-state, bus register and completion logic.
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      bus_err_d   = 1'b0;
      rd_data_d   = rd_data_q;
      addr_lo_d   = addr_lo_q;
      lo_d        = lo_q;
      size_d      = size_q;
      sign_d      = sign_q;
      cnt_d       = '0;
      stall       = 1'b0;
      case (state_q)
         IDLE: begin
            stall = access_s;
            if (access_s && trap_s) begin
               state_d   = DONE;
               bus_err_d = 1'b1;
               rd_data_d = 32'd0;
               addr_lo_d = addr[1:0];
            end else if (access_s) begin
               state_d     = BUSY;
               bus_req_d   = 1'b1;
               bus_we_d    = mem_wr;
               bus_addr_d  = {addr[31:2], 2'b00};
               bus_be_d    = be_decode(mem_size, addr[1:0]);
               bus_wdata_d = mem_wr ? store_lanes(mem_size, wdata) : 32'd0;
               lo_d        = addr[1:0];
               size_d      = mem_size;
               sign_d      = mem_sign;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            stall = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            // Ack takes priority over a timeout landing in the same cycle.
            if (bus_ack || timeout_s) begin
               state_d     = DONE;
               bus_req_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_addr_d  = 32'd0;
               bus_be_d    = 4'd0;
               bus_wdata_d = 32'd0;
               addr_lo_d   = lo_q;
               bus_err_d   = ~bus_ack;
               rd_data_d   = (bus_ack && !bus_we_q) ? load_data_s : 32'd0;
            end else begin
               state_d = BUSY;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_be_q    <= 4'd0;
         bus_wdata_q <= 32'd0;
         bus_err_q   <= 1'b0;
         rd_data_q   <= 32'd0;
         addr_lo_q   <= 2'd0;
         lo_q        <= 2'd0;
         size_q      <= 2'd0;
         sign_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         bus_err_q   <= bus_err_d;
         rd_data_q   <= rd_data_d;
         addr_lo_q   <= addr_lo_d;
         lo_q        <= lo_d;
         size_q      <= size_d;
         sign_q      <= sign_d;
         cnt_q       <= cnt_d;
      end
   end

   assign rd_data   = rd_data_q;
   assign addr_lo   = addr_lo_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed corner cases plus randomized accesses vs. a reference model.
module tb_dmem_access_ctrl;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_rd, mem_wr, mem_sign;
   logic [1:0]  mem_size;
   logic [31:0] addr, wdata;
   logic        stall;
   logic [31:0] rd_data;
   logic [1:0]  addr_lo;
   logic        bus_req, bus_we, bus_ack, bus_err;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_rd = 32'd0;

   dmem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_sign(mem_sign), .addr(addr), .wdata(wdata), .stall(stall), .rd_data(rd_data),
      .addr_lo(addr_lo), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, "_req"}, {31'd0, bus_req}, 32'd0);
      chk({tag, "_err"}, {31'd0, bus_err}, 32'd0);
      chk({tag, "_be"}, {28'd0, bus_be}, 32'd0);
      chk({tag, "_addr"}, bus_addr, 32'd0);
      chk({tag, "_rd"}, rd_data, 32'd0);
      chk({tag, "_lo"}, {30'd0, addr_lo}, 32'd0);
   endtask

   // One complete access. wait_n = BUSY cycles before ack; wait_n >= TO means no ack at all.
   task automatic access(input string tag, input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] a, input logic [31:0] wd, input int wait_n,
                         input logic [31:0] rdata);
      int sz, lo, nb, off, busy, stall_cnt;
      bit timeout, trap;
      logic [31:0] exp_be, exp_wd, exp_rd, raw, mask;
      sz  = (size == 2'd3) ? 2 : int'(size);
      lo  = int'(a[1:0]);
      nb  = 1 << sz;
      off = (sz == 0) ? lo : (sz == 1) ? (lo & 2) : 0;
      exp_be = (sz == 0) ? (32'd1 << lo) : (sz == 1) ? (32'd3 << (lo & 2)) : 32'd15;
      exp_wd = (sz == 0) ? wd[7:0] * 32'h01010101 : (sz == 1) ? wd[15:0] * 32'h00010001 : wd;
      raw = rdata >> (8 * off);
      if (nb < 4) begin
         mask = (32'd1 << (8 * nb)) - 32'd1;
         raw  = raw & mask;
         if (sgn && ((raw >> (8 * nb - 1)) & 32'd1) == 32'd1) raw = raw | ~mask;
      end
      timeout = (wait_n >= TO);
      trap = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      trap = (sz == 1 && (lo % 2) == 1) || (sz == 2 && lo != 0);
`endif
      exp_rd = (we || timeout || trap) ? 32'd0 : raw;

      @(negedge clk);
      mem_rd = ~we; mem_wr = we; mem_size = size; mem_sign = sgn; addr = a; wdata = wd;
      #1;
      chk({tag, "_idle_stall"}, {31'd0, stall}, 32'd1);
      chk({tag, "_idle_req"}, {31'd0, bus_req}, 32'd0);
      stall_cnt = 1;
      busy = trap ? 0 : (timeout ? TO : wait_n + 1);
      for (int i = 0; i < busy; i++) begin
         @(negedge clk);
         bus_ack   = (i == wait_n);
         bus_rdata = (i == wait_n) ? rdata : $urandom;
         #1;
         chk({tag, "_req"}, {31'd0, bus_req}, 32'd1);
         chk({tag, "_we"}, {31'd0, bus_we}, {31'd0, we});
         chk({tag, "_baddr"}, bus_addr, a & 32'hFFFF_FFFC);
         chk({tag, "_be"}, {28'd0, bus_be}, exp_be);
         if (we) chk({tag, "_wdata"}, bus_wdata, exp_wd);
         if (stall) stall_cnt++;
      end
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, "_done_req"}, {31'd0, bus_req}, 32'd0);
      chk({tag, "_done_err"}, {31'd0, bus_err}, {31'd0, (timeout | trap)});
      chk({tag, "_rd"}, rd_data, exp_rd);
      chk({tag, "_lo"}, {30'd0, addr_lo}, a & 32'd3);
      chk({tag, "_stall_cycles"}, stall_cnt, busy + 1);
      last_rd = exp_rd;
      mem_rd = 1'b0; mem_wr = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, "_no_reissue"}, {31'd0, bus_req}, 32'd0);
      chk({tag, "_err_pulse"}, {31'd0, bus_err}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; mem_size = 2'd0; mem_sign = 1'b0;
      addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      chk_idle_outputs("reset");
      reset = 1'b0;

      access("lb_sign", 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0, 0, {8'h80, 24'($urandom)});
      access("sh_lane", 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_BEEF, 0, 32'd0);
      access("lw_wait5", 1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'd0, 5, 32'hCAFE_F00D);
      access("lh_timeout", 1'b0, 2'b01, 1'b1, 32'h0000_3002, 32'd0, TO, 32'h0);
      access("lh_ack_last", 1'b0, 2'b01, 1'b1, 32'h0000_3002, 32'd0, TO - 1, 32'h8001_7FFF);
      access("lb_zero", 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'd0, 1, 32'h1234_F6AB);
      access("lw_rsvd", 1'b0, 2'b11, 1'b1, 32'h0000_0400, 32'd0, 0, 32'h8765_4321);

      // A stray ack while idle must not disturb anything.
      @(negedge clk);
      bus_ack = 1'b1; bus_rdata = $urandom;
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      chk("stray_ack_req", {31'd0, bus_req}, 32'd0);
      chk("stray_ack_err", {31'd0, bus_err}, 32'd0);
      chk("stray_ack_rd", rd_data, last_rd);

      for (int n = 0; n < 24; n++) begin
         access("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, int'($urandom_range(0, 3)), $urandom);
      end

      // Reset asserted in the middle of a bus transaction.
      access("pre_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'd0, 0, 32'h0BAD_BEEF);
      @(negedge clk);
      mem_rd = 1'b1; mem_size = 2'b10; addr = 32'h0000_0080;
      @(negedge clk);
      #1;
      chk("rst_busy_req", {31'd0, bus_req}, 32'd1);
      reset = 1'b1; mem_rd = 1'b0;
      #1;
      chk_idle_outputs("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      access("post_rst", 1'b0, 2'b00, 1'b1, 32'h0000_0082, 32'd0, 2, 32'h0055_7F00);

`ifdef DMEM_MISALIGN_TRAP_EN
      access("lw_trap", 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'd0, 0, 32'hFFFF_FFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
